// File: rtl/accum_alu_n_bits.sv
// Two-stage accumulator ALU: operand/op register, then ADD/SUB/LOAD/CLEAR into an N-bit accumulator with flags.
// Optional feature: define ACCUM_SATURATE_EN to clamp S to signed max/min on signed overflow.
module accum_alu_n_bits #(
  parameter int N = 8,
  parameter int C = 8
) (
  input  logic         clk,
  input  logic         aclr,
  input  logic [N-1:0] A,
  input  logic [1:0]   op,
  input  logic         in_valid,
  output logic [N-1:0] S,
  output logic         carry,
  output logic         overflow,
  output logic         ovf_sticky,
  output logic         zero,
  output logic         out_valid,
  output logic [C-1:0] op_cnt
);

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic [N-1:0] b_r;
  logic [1:0]   opr_r;
  logic         vld_r;

  logic [N-1:0] s_r;
  logic         carry_r;
  logic         ovf_r;
  logic         sticky_r;
  logic         zero_r;
  logic         out_valid_r;
  logic [C-1:0] cnt_r;

  logic [N:0]   wide_s;
  logic [N-1:0] s_next_s;
  logic         carry_next_s;
  logic         ovf_next_s;
  logic         sticky_next_s;

  // Signed overflow: operand signs must (ADD) or must not (SUB) match, and the result sign flips.
  function automatic logic signed_ovf(input logic sub, input logic sa, input logic sb, input logic sr);
    signed_ovf = ((sub ? (sa != sb) : (sa == sb)) && (sr != sa));
  endfunction

  // Stage 1: capture operand, op code and valid on every edge.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      b_r   <= {N{1'b0}};
      opr_r <= 2'b00;
      vld_r <= 1'b0;
    end else begin
      b_r   <= A;
      opr_r <= op;
      vld_r <= in_valid;
    end
  end

  // Stage 2 datapath: N+1-bit arithmetic so the top bit is carry (ADD) or borrow (SUB).
  always_comb begin
    wide_s        = {1'b0, s_r};
    carry_next_s  = 1'b0;
    ovf_next_s    = 1'b0;
    case (opr_r)
      OP_ADD: begin
        wide_s       = {1'b0, s_r} + {1'b0, b_r};
        carry_next_s = wide_s[N];
        ovf_next_s   = signed_ovf(1'b0, s_r[N-1], b_r[N-1], wide_s[N-1]);
      end
      OP_SUB: begin
        wide_s       = {1'b0, s_r} - {1'b0, b_r};
        carry_next_s = wide_s[N];
        ovf_next_s   = signed_ovf(1'b1, s_r[N-1], b_r[N-1], wide_s[N-1]);
      end
      OP_LOAD: begin
        wide_s = {1'b0, b_r};
      end
      OP_CLEAR: begin
        wide_s = {(N+1){1'b0}};
      end
      default: begin
        wide_s = {1'b0, s_r};
      end
    endcase
`ifdef ACCUM_SATURATE_EN
    // True result has the sign of S whenever overflow occurs, for both ADD and SUB.
    if (ovf_next_s) begin
      s_next_s = s_r[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end else begin
      s_next_s = wide_s[N-1:0];
    end
`else
    s_next_s = wide_s[N-1:0];
`endif
    if (opr_r == OP_CLEAR) begin
      sticky_next_s = 1'b0;
    end else begin
      sticky_next_s = sticky_r | ovf_next_s;
    end
  end

  // Stage 2 state: update accumulator and flags only when the stage-1 op is valid.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      s_r         <= {N{1'b0}};
      carry_r     <= 1'b0;
      ovf_r       <= 1'b0;
      sticky_r    <= 1'b0;
      zero_r      <= 1'b1;
      out_valid_r <= 1'b0;
      cnt_r       <= {C{1'b0}};
    end else if (vld_r) begin
      s_r         <= s_next_s;
      carry_r     <= carry_next_s;
      ovf_r       <= ovf_next_s;
      sticky_r    <= sticky_next_s;
      zero_r      <= (s_next_s == {N{1'b0}});
      out_valid_r <= 1'b1;
      cnt_r       <= cnt_r + {{(C-1){1'b0}}, 1'b1};
    end else begin
      out_valid_r <= 1'b0;
    end
  end

  assign S          = s_r;
  assign carry      = carry_r;
  assign overflow   = ovf_r;
  assign ovf_sticky = sticky_r;
  assign zero       = zero_r;
  assign out_valid  = out_valid_r;
  assign op_cnt     = cnt_r;

endmodule

// File: tb/tb_accum_alu_n_bits.sv
// Scoreboard bench for accum_alu_n_bits (N=8, C=8): directed ops push expected results, a monitor pops on out_valid.
module tb_accum_alu_n_bits;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic       clk;
  logic       aclr;
  logic [7:0] A;
  logic [1:0] op;
  logic       in_valid;
  logic [7:0] S;
  logic       carry;
  logic       overflow;
  logic       ovf_sticky;
  logic       zero;
  logic       out_valid;
  logic [7:0] op_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // {S, carry, overflow, ovf_sticky, zero, op_cnt}
  logic [19:0] exp_q[$];

  accum_alu_n_bits #(.N(8), .C(8)) dut (
    .clk(clk), .aclr(aclr), .A(A), .op(op), .in_valid(in_valid),
    .S(S), .carry(carry), .overflow(overflow), .ovf_sticky(ovf_sticky),
    .zero(zero), .out_valid(out_valid), .op_cnt(op_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [19:0] act, input logic [19:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %05h expected %05h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send(input logic [1:0] o, input logic [7:0] a, input logic [7:0] es,
                      input logic ec, input logic eo, input logic est, input logic ez,
                      input logic [7:0] ecnt);
    @(negedge clk);
    op       = o;
    A        = a;
    in_valid = 1'b1;
    exp_q.push_back({es, ec, eo, est, ez, ecnt});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  // Monitor: every out_valid cycle must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (aclr && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", {S, carry, overflow, ovf_sticky, zero, op_cnt}, 20'h0);
        if ({S, carry, overflow, ovf_sticky, zero, op_cnt} == 20'h0) begin
          n_bad++;
          $display("FAIL unexpected_out_valid: got out_valid=1 expected 0 at %0t", $time);
        end
      end else begin
        chk("result", {S, carry, overflow, ovf_sticky, zero, op_cnt}, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [7:0] s_m;
    logic       st_m;
    int         wait_cyc;
    aclr     = 1'b0;
    A        = 8'h00;
    op       = 2'b00;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_in", {S, carry, overflow, ovf_sticky, zero, op_cnt}, {8'h00, 4'b0001, 8'h00});
    chk("reset_in_valid", {19'h0, out_valid}, 20'h0);
    aclr = 1'b1;
    idle(2);
    chk("reset_rel", {S, carry, overflow, ovf_sticky, zero, op_cnt}, {8'h00, 4'b0001, 8'h00});
    chk("reset_rel_valid", {19'h0, out_valid}, 20'h0);

    // LOAD then ADD back-to-back
    send(OP_LOAD, 8'h10, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
    send(OP_ADD,  8'h05, 8'h15, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2);
    idle(4);
    chk("hold_idle", {S, carry, overflow, ovf_sticky, zero, op_cnt}, {8'h15, 4'b0000, 8'd2});

    // Signed overflow on ADD
    send(OP_LOAD, 8'h7F, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3);
`ifdef ACCUM_SATURATE_EN
    send(OP_ADD,  8'h01, 8'h7F, 1'b0, 1'b1, 1'b1, 1'b0, 8'd4);
`else
    send(OP_ADD,  8'h01, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 8'd4);
`endif
    // Borrow without overflow, then signed overflow on SUB
    send(OP_LOAD, 8'h05, 8'h05, 1'b0, 1'b0, 1'b1, 1'b0, 8'd5);
    send(OP_SUB,  8'h06, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 8'd6);
    send(OP_LOAD, 8'h80, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0, 8'd7);
`ifdef ACCUM_SATURATE_EN
    send(OP_SUB,  8'h7F, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 8'd8);
`else
    send(OP_SUB,  8'h7F, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 8'd8);
`endif
    // Unsigned wrap to zero, CLEAR drops sticky, SUB to exact zero
    send(OP_LOAD,  8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 8'd9);
    send(OP_ADD,   8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'd10);
    send(OP_CLEAR, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'd11);
    send(OP_LOAD,  8'h33, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 8'd12);
    send(OP_SUB,   8'h33, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'd13);
    idle(4);

    // Pending op is discarded by an async reset
    @(negedge clk);
    op = OP_LOAD; A = 8'h44; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    aclr     = 1'b0;
    @(negedge clk);
    aclr = 1'b1;
    idle(4);
    chk("drop_pending", {S, carry, overflow, ovf_sticky, zero, op_cnt}, {8'h00, 4'b0001, 8'h00});

    // 256 consecutive ADD 1 ops: op_cnt wraps to 0
    s_m  = 8'h00;
    st_m = 1'b0;
    for (int i = 1; i <= 256; i++) begin
      logic [8:0] w;
      logic       ov;
      logic [7:0] r;
      w  = {1'b0, s_m} + 9'd1;
      ov = (s_m == 8'h7F);
`ifdef ACCUM_SATURATE_EN
      r = ov ? 8'h7F : w[7:0];
`else
      r = w[7:0];
`endif
      st_m = st_m | ov;
      send(OP_ADD, 8'h01, r, w[8], ov, st_m, (r == 8'h00), i[7:0]);
      s_m = r;
    end
    idle(1);

    wait_cyc = 0;
    while (exp_q.size() != 0 && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    chk("drain", {12'h0, exp_q.size() == 0 ? 8'h00 : 8'h01}, 20'h0);
    chk("final_cnt", {12'h0, op_cnt}, 20'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
